reg_write_demux_4x16: RTL and testbench
=======================================

Name: reg_write_demux_4x16

Overview:
- Write-side counterpart of the 4:1 16-bit register read mux.
- Accepts 16-bit write requests tagged with a 2-bit register selector and byte enables, and queues them in a 2-entry in-order buffer.
- Commits one request per cycle into four 16-bit registers.
- Presents all four registers as a packed 64-bit bus that feeds the read mux's data input directly.

Parameters:
- RESET_VALUE, 16'h0000, reset value loaded into all four registers.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- write_valid  input  1  write request present.
- write_ready  output  1  block can accept a request this cycle.
- write_selector  input  2  destination register index k (0..3).
- write_data  input  16  write data.
- write_byte_enable  input  2  bit0 = low byte [7:0], bit1 = high byte [15:8].
- commit_hold  input  1  when 1, no queued entry commits this cycle.
- packed_output  output  64  register k on [16k+15:16k]; selector value k on the read mux returns register k.
- pending_count  output  2  number of queued entries (0..2).
- busy  output  1  pending_count != 0.

Behaviour:
- Reset: while reset_n is low at a clock edge:
  - all four registers load RESET_VALUE;
  - the queue empties, so pending_count = 0 and busy = 0;
  - any in-flight request is discarded.
- write_ready is forced to 0 while reset_n is low.
- packed_output after reset = {4{RESET_VALUE}}.
- Queue: 2-entry FIFO of {selector, data, byte_enable}; strict in-order commit.
- write_ready = reset_n && (pending_count < 2). It depends only on registered count, with no combinational path from commit_hold or write_valid.
- Accept: write_valid && write_ready at edge N enqueues the entry at the tail.
- Commit: at any edge where pending_count > 0 and commit_hold = 0, the head entry is applied and dequeued.
  - Register[sel][7:0] takes data[7:0] if be[0] = 1.
  - Register[sel][15:8] takes data[15:8] if be[1] = 1.
  - Unselected registers and disabled lanes hold their values.
- be = 2'b00: entry is still accepted and still consumes a commit cycle; no register changes.
- Latency: an entry accepted at edge N into an empty queue commits at edge N+1 at the earliest, so packed_output reflects it after N+1. Minimum accept-to-visible latency is 2 edges from request presentation. There is no bypass.
- Simultaneous accept and commit in the same cycle is allowed:
  - pending_count is unchanged;
  - the new entry goes behind the remaining entry;
  - when pending_count = 1, the committing head and the new tail never collide.
- Full (count = 2): write_ready = 0 even if a commit happens this cycle. The freed slot is usable from the next cycle.
- Empty: commit_hold has no effect; busy = 0.
- Same-register back-to-back writes: later entry wins per lane; lanes it does not enable keep the earlier entry's bytes.
- commit_hold held indefinitely: the queue fills to 2, then write_ready stays 0. No loss and no overwrite of queued entries.
- write_valid while write_ready = 0: the request is ignored. The requester must hold it stable.
- pending_count wraps never. Legal range is 0..2; the value 3 is unreachable.
- Reset mid-operation: queued, uncommitted entries are dropped and registers return to RESET_VALUE on that edge.

Test Plan:
1. Reset, then write sel=2, data=16'hBEEF, be=2'b11, no hold.
   - Required: accepted at edge 1, packed_output[47:32] = 16'hBEEF after edge 2.
   - Other slices stay 16'h0000; pending_count sequence is 0,1,0.
2. Partial lanes: reg1 = 16'h1234, then write sel=1, data=16'hAB00, be=2'b10.
   - Required: reg1 = 16'hAB34.
   - A following be=2'b00 write changes nothing but still takes a commit cycle.
3. Backpressure: hold commit_hold = 1 and offer 3 writes (sel=0, data 16'h0001/0002/0003).
   - Required: first two are accepted, pending_count = 2, write_ready = 0 and the third is stalled.
   - Release hold: commits occur in order, reg0 = 16'h0003 finally, and exactly 3 commits total.
4. Simultaneous accept and commit at count=1: write_valid every cycle with no hold.
   - Required: count stays at 1 and one commit per cycle.
   - Streamed sel=0..3 with data = 16'h1111 * (k+1) yields packed_output = 64'h4444_3333_2222_1111.
5. Reset mid-operation: with 2 entries queued under hold, assert reset_n = 0 for one edge.
   - Required: pending_count = 0, packed_output = {4{RESET_VALUE}}, and write_ready = 0 during reset then 1 after.
   - No queued write ever appears.

Source files
------------

// File: rtl/reg_write_demux_4x16.sv
// ---------------------------------------------------------------------------
// reg_write_demux_4x16
//
// Purpose:
//   Write-side companion of the 4:1 16-bit register read mux. Byte-enabled
//   write requests tagged with a 2-bit register selector are queued in a
//   2-entry in-order buffer. At most one queued entry per cycle is committed
//   into one of four 16-bit registers. All four registers are exposed as a
//   packed 64-bit bus that feeds the read mux directly.
//
// Parameters:
//   RESET_VALUE        value loaded into every register on reset
//
// Ports:
//   clock              system clock, rising-edge active
//   reset_n            synchronous active-low reset
//   write_valid        write request present
//   write_ready        request can be accepted this cycle
//   write_selector     destination register index (0..3)
//   write_data         16-bit write data
//   write_byte_enable  bit0 -> [7:0], bit1 -> [15:8]
//   commit_hold        when 1, the queue head is not committed this cycle
//   packed_output      register k on [16k+15:16k]
//   pending_count      number of queued entries (0..2)
//   busy               pending_count != 0
// ---------------------------------------------------------------------------
module reg_write_demux_4x16 #(
  parameter logic [15:0] RESET_VALUE = 16'h0000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        write_valid,
  output logic        write_ready,
  input  logic [1:0]  write_selector,
  input  logic [15:0] write_data,
  input  logic [1:0]  write_byte_enable,
  input  logic        commit_hold,
  output logic [63:0] packed_output,
  output logic [1:0]  pending_count,
  output logic        busy
);

  // Apply a byte-enabled write to a 16-bit value; disabled lanes keep old bytes.
  function automatic logic [15:0] merge_lanes(
    input logic [15:0] old_value,
    input logic [15:0] new_value,
    input logic [1:0]  byte_enable
  );
    logic [15:0] result;
    result        = old_value;
    if (byte_enable[0]) begin
      result[7:0] = new_value[7:0];
    end else begin
      result[7:0] = old_value[7:0];
    end
    if (byte_enable[1]) begin
      result[15:8] = new_value[15:8];
    end else begin
      result[15:8] = old_value[15:8];
    end
    return result;
  endfunction

  // Register file
  logic [15:0] r_regs [4];

  // Queue storage: slot 0 is always the head, slot 1 the second entry.
  logic [1:0]  r_q_sel  [2];
  logic [15:0] r_q_data [2];
  logic [1:0]  r_q_be   [2];
  logic [1:0]  r_count;

  logic w_accept;
  logic w_commit;
  logic w_tail_is_one;

  // Handshake and queue control; ready looks only at the registered count.
  always_comb begin
    write_ready   = 1'b0;
    w_accept      = 1'b0;
    w_commit      = 1'b0;
    w_tail_is_one = 1'b0;
    if (reset_n && (r_count < 2'd2)) begin
      write_ready = 1'b1;
    end else begin
      write_ready = 1'b0;
    end
    w_accept = write_valid && write_ready;
    if ((r_count != 2'd0) && !commit_hold) begin
      w_commit = 1'b1;
    end else begin
      w_commit = 1'b0;
    end
    // New entry lands in slot 1 only if slot 0 stays occupied this cycle.
    // With one entry committing, the head slot is freed and reused.
    if ((r_count == 2'd1) && !w_commit) begin
      w_tail_is_one = 1'b1;
    end else begin
      w_tail_is_one = 1'b0;
    end
  end

  // Queue state, commit into the register file, and synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_regs[i] <= RESET_VALUE;
      end
      for (int j = 0; j < 2; j++) begin
        r_q_sel[j]  <= 2'd0;
        r_q_data[j] <= 16'h0000;
        r_q_be[j]   <= 2'b00;
      end
    end else begin
      if (w_commit) begin
        r_regs[r_q_sel[0]] <= merge_lanes(r_regs[r_q_sel[0]], r_q_data[0], r_q_be[0]);
        // Shift the second entry forward; only meaningful when two were queued.
        if (r_count == 2'd2) begin
          r_q_sel[0]  <= r_q_sel[1];
          r_q_data[0] <= r_q_data[1];
          r_q_be[0]   <= r_q_be[1];
        end else begin
          r_q_sel[0]  <= r_q_sel[0];
          r_q_data[0] <= r_q_data[0];
          r_q_be[0]   <= r_q_be[0];
        end
      end else begin
        r_q_sel[0]  <= r_q_sel[0];
        r_q_data[0] <= r_q_data[0];
        r_q_be[0]   <= r_q_be[0];
      end

      // Accept is impossible at count 2, so it never races the shift above.
      if (w_accept) begin
        if (w_tail_is_one) begin
          r_q_sel[1]  <= write_selector;
          r_q_data[1] <= write_data;
          r_q_be[1]   <= write_byte_enable;
        end else begin
          r_q_sel[0]  <= write_selector;
          r_q_data[0] <= write_data;
          r_q_be[0]   <= write_byte_enable;
        end
      end else begin
        r_q_sel[1]  <= r_q_sel[1];
        r_q_data[1] <= r_q_data[1];
        r_q_be[1]   <= r_q_be[1];
      end

      case ({w_accept, w_commit})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        2'b11:   r_count <= r_count;
        2'b00:   r_count <= r_count;
        default: r_count <= r_count;
      endcase
    end
  end

  assign packed_output = {r_regs[3], r_regs[2], r_regs[1], r_regs[0]};
  assign pending_count = r_count;
  assign busy          = (r_count != 2'd0);

endmodule

// File: tb/tb_reg_write_demux_4x16.sv
// ---------------------------------------------------------------------------
// tb_reg_write_demux_4x16
//
// Directed-vector bench for reg_write_demux_4x16. Inputs change 1 time unit
// after each rising edge and outputs are sampled at that same point, well
// away from the active edge.
// ---------------------------------------------------------------------------
module tb_reg_write_demux_4x16;

  logic        clock;
  logic        reset_n;
  logic        write_valid;
  logic        write_ready;
  logic [1:0]  write_selector;
  logic [15:0] write_data;
  logic [1:0]  write_byte_enable;
  logic        commit_hold;
  logic [63:0] packed_output;
  logic [1:0]  pending_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  reg_write_demux_4x16 #(.RESET_VALUE(16'h0000)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .write_valid       (write_valid),
    .write_ready       (write_ready),
    .write_selector    (write_selector),
    .write_data        (write_data),
    .write_byte_enable (write_byte_enable),
    .commit_hold       (commit_hold),
    .packed_output     (packed_output),
    .pending_count     (pending_count),
    .busy              (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d, input logic [1:0] be);
    write_valid       = v;
    write_selector    = s;
    write_data        = d;
    write_byte_enable = be;
  endtask

  initial begin
    reset_n     = 1'b0;
    commit_hold = 1'b0;
    drive(1'b0, 2'd0, 16'h0000, 2'b00);

    // ---------------- Reset state
    tick();
    tick();
    chk("rst_packed", packed_output, 64'h0);
    chk("rst_count", {62'd0, pending_count}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready_low", {63'd0, write_ready}, 64'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_ready_high", {63'd0, write_ready}, 64'd1);

    // ---------------- Test 1: single full write to reg2
    drive(1'b1, 2'd2, 16'hBEEF, 2'b11);
    tick();                                   // edge 1: accepted
    drive(1'b0, 2'd0, 16'h0000, 2'b00);
    chk("t1_count_e1", {62'd0, pending_count}, 64'd1);
    chk("t1_busy_e1", {63'd0, busy}, 64'd1);
    chk("t1_no_bypass", packed_output, 64'h0);
    tick();                                   // edge 2: committed
    chk("t1_count_e2", {62'd0, pending_count}, 64'd0);
    chk("t1_packed", packed_output, 64'h0000_BEEF_0000_0000);

    // ---------------- Test 2: partial lanes on reg1
    drive(1'b1, 2'd1, 16'h1234, 2'b11);
    tick();
    drive(1'b0, 2'd0, 16'h0000, 2'b00);
    tick();
    chk("t2_reg1_full", {48'd0, packed_output[31:16]}, 64'h1234);
    drive(1'b1, 2'd1, 16'hAB00, 2'b10);
    tick();
    drive(1'b0, 2'd0, 16'h0000, 2'b00);
    tick();
    chk("t2_reg1_hi", {48'd0, packed_output[31:16]}, 64'hAB34);
    drive(1'b1, 2'd1, 16'hFFFF, 2'b00);
    tick();
    drive(1'b0, 2'd0, 16'h0000, 2'b00);
    chk("t2_be0_queued", {62'd0, pending_count}, 64'd1);
    tick();
    chk("t2_be0_drained", {62'd0, pending_count}, 64'd0);
    chk("t2_be0_nochange", packed_output, 64'h0000_BEEF_AB34_0000);

    // ---------------- Test 3: backpressure under commit_hold
    commit_hold = 1'b1;
    drive(1'b1, 2'd0, 16'h0001, 2'b11);
    tick();
    chk("t3_count1", {62'd0, pending_count}, 64'd1);
    drive(1'b1, 2'd0, 16'h0002, 2'b11);
    tick();
    chk("t3_count2", {62'd0, pending_count}, 64'd2);
    chk("t3_ready0", {63'd0, write_ready}, 64'd0);
    drive(1'b1, 2'd0, 16'h0003, 2'b11);
    tick();
    chk("t3_stall_count", {62'd0, pending_count}, 64'd2);
    chk("t3_stall_ready", {63'd0, write_ready}, 64'd0);
    chk("t3_hold_reg0", {48'd0, packed_output[15:0]}, 64'h0000);
    commit_hold = 1'b0;
    tick();                                   // commit 1, full -> no accept
    chk("t3_commit1", {48'd0, packed_output[15:0]}, 64'h0001);
    chk("t3_count_a", {62'd0, pending_count}, 64'd1);
    tick();                                   // commit 2, accept 3
    drive(1'b0, 2'd0, 16'h0000, 2'b00);
    chk("t3_commit2", {48'd0, packed_output[15:0]}, 64'h0002);
    chk("t3_count_b", {62'd0, pending_count}, 64'd1);
    tick();                                   // commit 3
    chk("t3_commit3", {48'd0, packed_output[15:0]}, 64'h0003);
    chk("t3_count_c", {62'd0, pending_count}, 64'd0);
    tick();
    chk("t3_exactly3", packed_output, 64'h0000_BEEF_AB34_0003);

    // ---------------- Test 4: streaming, simultaneous accept and commit
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, k[1:0], 16'h1111 * 16'(k + 1), 2'b11);
      tick();
      chk($sformatf("t4_count_%0d", k), {62'd0, pending_count}, 64'd1);
      if (k > 0) begin
        chk($sformatf("t4_reg_%0d", k - 1), {48'd0, packed_output[16*(k-1) +: 16]},
            {48'd0, 16'h1111 * 16'(k)});
      end
    end
    drive(1'b0, 2'd0, 16'h0000, 2'b00);
    tick();
    chk("t4_count_end", {62'd0, pending_count}, 64'd0);
    chk("t4_packed", packed_output, 64'h4444_3333_2222_1111);

    // ---------------- Test 5: reset with two entries queued under hold
    commit_hold = 1'b1;
    drive(1'b1, 2'd3, 16'h5555, 2'b11);
    tick();
    drive(1'b1, 2'd2, 16'h6666, 2'b11);
    tick();
    drive(1'b0, 2'd0, 16'h0000, 2'b00);
    chk("t5_count2", {62'd0, pending_count}, 64'd2);
    reset_n = 1'b0;
    #1;
    chk("t5_ready_in_rst", {63'd0, write_ready}, 64'd0);
    tick();
    chk("t5_count0", {62'd0, pending_count}, 64'd0);
    chk("t5_busy0", {63'd0, busy}, 64'd0);
    chk("t5_packed_rst", packed_output, 64'h0);
    reset_n     = 1'b1;
    commit_hold = 1'b0;
    #1;
    chk("t5_ready_after", {63'd0, write_ready}, 64'd1);
    tick();
    tick();
    tick();
    chk("t5_no_ghost", packed_output, 64'h0);
    chk("t5_count_idle", {62'd0, pending_count}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
